// File: rtl/dmi_chain_driver.sv
// Serial initiator for the 41-bit DMI capture/shift/update chain.
// Optional simulation checks are enabled by defining DMI_CHAIN_DRIVER_ASSERT_EN.
module dmi_chain_driver #(
  parameter int IDLE_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [6:0]  io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic [1:0]  io_req_bits_op,
  output logic        io_rsp_valid,
  input  logic        io_rsp_ready,
  output logic [6:0]  io_rsp_bits_addr,
  output logic [31:0] io_rsp_bits_data,
  output logic [1:0]  io_rsp_bits_resp,
  output logic        io_chainOut_capture,
  output logic        io_chainOut_shift,
  output logic        io_chainOut_update,
  output logic        io_chainOut_data,
  input  logic        io_chainIn_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_UPDATE  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [5:0] LAST_BIT  = 6'd40;
  localparam logic [7:0] WAIT_LAST = (IDLE_CYCLES > 0) ? 8'(IDLE_CYCLES - 1) : 8'd0;

  logic [2:0]  state_r;
  logic [40:0] tx_r;
  logic [40:0] rx_r;
  logic [5:0]  cnt_r;
  logic [7:0]  wait_cnt_r;

  // Scan sequencer: one capture, 41 shifts, one update, optional idle, then response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      tx_r       <= 41'd0;
      rx_r       <= 41'd0;
      cnt_r      <= 6'd0;
      wait_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (io_req_valid) begin
            tx_r    <= {io_req_bits_addr, io_req_bits_data, io_req_bits_op};
            cnt_r   <= 6'd0;
            state_r <= S_CAPTURE;
          end
        end
        S_CAPTURE: state_r <= S_SHIFT;
        S_SHIFT: begin
          rx_r[cnt_r] <= io_chainIn_data;
          if (cnt_r == LAST_BIT) begin
            state_r <= S_UPDATE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        S_UPDATE: begin
          wait_cnt_r <= 8'd0;
          state_r    <= (IDLE_CYCLES > 0) ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_RESP: begin
          if (io_rsp_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state; rx is frozen outside SHIFT.
  assign io_req_ready        = (state_r == S_IDLE);
  assign io_rsp_valid        = (state_r == S_RESP);
  assign io_chainOut_capture = (state_r == S_CAPTURE);
  assign io_chainOut_shift   = (state_r == S_SHIFT);
  assign io_chainOut_update  = (state_r == S_UPDATE);
  assign io_chainOut_data    = (state_r == S_SHIFT) ? tx_r[cnt_r] : 1'b0;
  assign io_rsp_bits_addr    = rx_r[40:34];
  assign io_rsp_bits_data    = rx_r[33:2];
  assign io_rsp_bits_resp    = rx_r[1:0];

`ifdef DMI_CHAIN_DRIVER_ASSERT_EN
`ifndef SYNTHESIS
  logic [6:0]  chk_shift_cnt_r;
  logic        chk_hold_r;
  logic [40:0] chk_rsp_r;

  // Protocol checks: control exclusivity, held response stability, 41 shifts per scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_shift_cnt_r <= 7'd0;
      chk_hold_r      <= 1'b0;
      chk_rsp_r       <= 41'd0;
    end else begin
      if ($countones({io_chainOut_capture, io_chainOut_shift, io_chainOut_update}) > 1) begin
        $error("dmi_chain_driver: chain controls not exclusive");
        $fatal(1, "dmi_chain_driver: check failed");
      end
      if (chk_hold_r && (chk_rsp_r != {io_rsp_bits_addr, io_rsp_bits_data, io_rsp_bits_resp})) begin
        $error("dmi_chain_driver: response changed while stalled");
        $fatal(1, "dmi_chain_driver: check failed");
      end
      chk_hold_r <= io_rsp_valid && !io_rsp_ready;
      chk_rsp_r  <= {io_rsp_bits_addr, io_rsp_bits_data, io_rsp_bits_resp};
      if (io_chainOut_update) begin
        if (chk_shift_cnt_r != 7'd41) begin
          $error("dmi_chain_driver: scan shifted %0d bits", chk_shift_cnt_r);
          $fatal(1, "dmi_chain_driver: check failed");
        end
        chk_shift_cnt_r <= 7'd0;
      end else if (io_chainOut_shift) begin
        chk_shift_cnt_r <= chk_shift_cnt_r + 7'd1;
      end else begin
        chk_shift_cnt_r <= chk_shift_cnt_r;
      end
    end
  end
`endif
`endif

endmodule

// File: doc/dmi_chain_driver.md
# dmi_chain_driver

Host-side serial driver for the 41-bit DMI JTAG capture/update chain. It takes a parallel DMI request (addr, data, op) and runs one capture, 41 shift and one update sequence on the chain's `chainIn` port. While shifting, it serialises the request into the chain and deserialises the chain's captured word from `chainOut_data`. The block is used in simulation harnesses and in the on-chip test-access bridge as the initiator for the chain's receiver side.

## Interface

Parameters:
- `IDLE_CYCLES`, default 0: run-test-idle cycles inserted after the update pulse and before the response is presented (0–255).

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `io_req_valid` in 1: request present.
- `io_req_ready` out 1: request accepted when high with valid. Equal to (state == IDLE).
- `io_req_bits_addr` in 7: DMI address.
- `io_req_bits_data` in 32: DMI write data.
- `io_req_bits_op` in 2: DMI op (0 nop, 1 read, 2 write).
- `io_rsp_valid` out 1: scan result present.
- `io_rsp_ready` in 1: result consumed when high with valid.
- `io_rsp_bits_addr` out 7: captured address field.
- `io_rsp_bits_data` out 32: captured data field.
- `io_rsp_bits_resp` out 2: captured response field.
- `io_chainOut_capture` out 1: drives the chain's `chainIn_capture`.
- `io_chainOut_shift` out 1: drives the chain's `chainIn_shift`.
- `io_chainOut_update` out 1: drives the chain's `chainIn_update`.
- `io_chainOut_data` out 1: drives the chain's `chainIn_data`.
- `io_chainIn_data` in 1: from the chain's `chainOut_data`.

## Operation

- **Word format, 41 bits, bit 0 first on the wire:** [1:0] op/resp, [33:2] data, [40:34] addr.
- **States:** IDLE → CAPTURE → SHIFT → UPDATE → WAIT → RESP → IDLE.
- **IDLE**
  - `io_req_ready`=1.
  - On valid&ready, latch {addr, data, op} into the 41-bit `tx` register, clear the bit counter, and go to CAPTURE.
- **CAPTURE** (1 cycle)
  - `capture`=1; shift, update and data are 0.
  - Go to SHIFT.
- **SHIFT** (exactly 41 cycles, counter 0..40)
  - `shift`=1.
  - `io_chainOut_data` = `tx[cnt]`.
  - At each edge, `rx[cnt]` ← `io_chainIn_data`.
  - At cnt==40, go to UPDATE. The counter is 6 bits and never wraps past 40.
- **UPDATE** (1 cycle)
  - `update`=1.
  - Go to WAIT if IDLE_CYCLES>0, else go to RESP.
- **WAIT**
  - Counts IDLE_CYCLES cycles with all chain controls 0, then goes to RESP.
- **RESP**
  - `io_rsp_valid`=1, with bits taken from `rx`.
  - Hold until `io_rsp_ready`, then go to IDLE.
  - Bits stay stable while valid&!ready.
- **Response semantics:** the response reports what the chain captured at the start of this scan, i.e. the result of the previous DMI op. It is not the result of the request just shifted in. Upstream is responsible for issuing a trailing nop to collect a final result.
- **Control exclusivity:** capture, shift and update are mutually exclusive in every cycle. All four chain outputs are 0 outside their own state.
- **Back-to-back requests:** a new request is not accepted in the cycle rsp is consumed. `io_req_ready` rises the following cycle.
- **Reset:**
  - Any state returns to IDLE on the edge where `reset` is sampled high, including mid-SHIFT; the partial scan is discarded.
  - During reset: `io_req_ready`=1; `io_rsp_valid`, capture, shift, update and `io_chainOut_data` are all 0.
  - `tx`, `rx` and the counters reset to 0.

## Timing

- Request handshake at edge T.
- `capture` high in cycle T+1.
- `shift` high in cycles T+2..T+42.
- `update` high in cycle T+43.
- `io_rsp_valid` first high in cycle T+44+IDLE_CYCLES.
- All outputs are registered state decodes; `io_chainOut_data` is a mux of `tx` by the registered counter.
- No combinational path from `io_chainIn_data` or `io_rsp_ready` to any output.

## Configuration

- `DMI_CHAIN_DRIVER_ASSERT_EN`
  - **Defined:** simulation-only checks (inside `ifndef SYNTHESIS`) fire `$error` then `$fatal` when, with reset low:
    - more than one of capture/shift/update is high;
    - rsp bits change while valid&!ready;
    - the shift count in a scan is not equal to 41.
  - **Undefined:** no checks are compiled. Synthesised logic is identical either way.

## Test plan

- **Reset:** hold `reset` 3 cycles with `io_req_valid`=1 → `io_req_ready`=1, all chain outputs 0, `io_rsp_valid`=0, nothing accepted.
- **Write:**
  - Stimulus: chain model with capture bits addr=0x05, data=0x12345678, resp=0; request addr=0x10, data=0xDEADBEEF, op=2.
  - Chain: update pulse at T+43, chain presents update addr=0x10, data=0xDEADBEEF, op=2.
  - Driver: rsp addr=0x05, data=0x12345678, resp=0 at T+44.
- **Backpressure:** `io_rsp_ready`=0 for 10 cycles → rsp stays valid and stable, `io_req_ready`=0. Ready=1 → accepted; `io_req_ready`=1 the next cycle.
- **Back-to-back:** read addr=0x11, then nop, with the chain model returning data=0xCAFEF00D resp=0 on the second capture → the second rsp carries 0xCAFEF00D. Exactly two captures, 82 shifts and two updates are observed.
- **Reset mid-operation:** assert `reset` at shift cycle 20 → next cycle IDLE, no update pulse, no rsp. A following request completes normally.
- **IDLE_CYCLES=3:** rsp_valid first appears at T+47, and chain controls are 0 in T+44..T+46.
